// File: rtl/muldiv_sched_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
//   muldiv_op_t    : operation encoding presented by each issue lane
//   muldiv_state_t : scheduler FSM states
//   muldiv_req_t   : the request selected by arbitration
package muldiv_sched_pkg;

    localparam int MULDIV_DIV_CYCLES = 32;
    localparam int MULDIV_CNT_W      = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    typedef struct packed {
        logic        valid;
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
    } muldiv_req_t;

    // Two's-complement negate with natural 32-bit wrap.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic is_div_op(input muldiv_op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sched_div_radix2.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : load operands (magnitudes for signed divide)
//   flush             : abandon the current divide
//   is_signed         : DIV (1) versus DIVU (0)
//   a, b              : dividend, divisor
//   ready             : no iteration pending; quo/rem reflect the last divide
//   quo, rem          : sign-corrected quotient and remainder
module muldiv_sched_div_radix2
    import muldiv_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0]             rem_q, rem_d;
    logic [31:0]             quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [31:0]             dvs_q, dvs_d;
    logic [31:0]             a_raw_q, a_raw_d;  // original dividend, returned as HI on divide by zero
    logic                    neg_quo_q, neg_quo_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    dz_q, dz_d;
    logic [MULDIV_CNT_W-1:0] count_q, count_d;

    logic [32:0] partial_s;
    logic [31:0] diff_s;
    logic        borrow_s;
    logic        a_neg_s;
    logic        b_neg_s;

    // Load, iterate or abandon the divide.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        a_raw_d   = a_raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        count_d   = count_q;
        a_neg_s   = is_signed & a[31];
        b_neg_s   = is_signed & b[31];
        partial_s = {rem_q, quo_q[31]};
        borrow_s  = partial_s < {1'b0, dvs_q};
        // When no borrow occurs the difference is below the divisor, so it fits 32 bits.
        diff_s    = 32'(partial_s - {1'b0, dvs_q});
        if (flush) begin
            count_d = {MULDIV_CNT_W{1'b0}};
        end else if (start) begin
            rem_d     = 32'd0;
            quo_d     = a_neg_s ? neg32(a) : a;
            dvs_d     = b_neg_s ? neg32(b) : b;
            a_raw_d   = a;
            neg_quo_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            dz_d      = (b == 32'd0);
            count_d   = MULDIV_CNT_W'(MULDIV_DIV_CYCLES);
        end else if (count_q != {MULDIV_CNT_W{1'b0}}) begin
            rem_d   = borrow_s ? partial_s[31:0] : diff_s;
            quo_d   = {quo_q[30:0], ~borrow_s};
            count_d = count_q - {{(MULDIV_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Divider datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            a_raw_q   <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            count_q   <= {MULDIV_CNT_W{1'b0}};
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            a_raw_q   <= a_raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            count_q   <= count_d;
        end
    end

    // Sign correction; divide by zero bypasses it and returns the raw dividend.
    always_comb begin
        ready = (count_q == {MULDIV_CNT_W{1'b0}});
        if (dz_q) begin
            quo = 32'hFFFF_FFFF;
            rem = a_raw_q;
        end else begin
            quo = neg_quo_q ? neg32(quo_q) : quo_q;
            rem = neg_rem_q ? neg32(rem_q) : rem_q;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// Shared multiply/divide scheduler for a dual-issue pipeline.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   req[1:0]     : per-lane request, lane 1 is the older slot and wins
//   op, src_a/b  : per-lane operation and operands
//   flush        : abort in-flight work (a result already in DONE still pulses)
//   grant        : one-hot lane accepted this cycle (combinational)
//   busy, stall  : operation in flight / pipeline stall request
//   done, hi, lo : one-cycle completion pulse and HI/LO result
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0][1:0]  op,
    input  logic [1:0][31:0] src_a,
    input  logic [1:0][31:0] src_b,
    input  logic             flush,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [31:0]      hi,
    output logic [31:0]      lo
);

    localparam int DIV_ITER = MULDIV_DIV_CYCLES;
    localparam logic [MULDIV_CNT_W-1:0] CNT_ZERO = {MULDIV_CNT_W{1'b0}};
    localparam logic [MULDIV_CNT_W-1:0] CNT_ONE  = {{(MULDIV_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [MULDIV_CNT_W-1:0] CNT_MUL  = MULDIV_CNT_W'(MUL_LAT - 32'sd1);
    localparam logic [MULDIV_CNT_W-1:0] CNT_DIV  = MULDIV_CNT_W'(DIV_ITER);

    muldiv_state_t           state_q, state_d;
    logic [MULDIV_CNT_W-1:0] counter_q, counter_d;
    logic [63:0]             prod_q, prod_d;
    logic [31:0]             hi_q, hi_d;
    logic [31:0]             lo_q, lo_d;

    muldiv_req_t sel_s;
    logic [1:0]  grant_s;
    logic        mul_signed_s;
    logic [63:0] a_ext_s, b_ext_s, product_s;
    logic        div_start_s, div_ready_s;
    logic [31:0] div_quo_s, div_rem_s;

    // Arbitration: accept only in IDLE without flush; lane 1 has priority.
    always_comb begin
        grant_s     = 2'b00;
        sel_s.valid = 1'b0;
        sel_s.op    = muldiv_op_t'(op[0]);
        sel_s.a     = src_a[0];
        sel_s.b     = src_b[0];
        if ((state_q == ST_IDLE) && !flush) begin
            if (req[1]) begin
                grant_s     = 2'b10;
                sel_s.valid = 1'b1;
                sel_s.op    = muldiv_op_t'(op[1]);
                sel_s.a     = src_a[1];
                sel_s.b     = src_b[1];
            end else if (req[0]) begin
                grant_s     = 2'b01;
                sel_s.valid = 1'b1;
            end else begin
                grant_s = 2'b00;
            end
        end else begin
            grant_s = 2'b00;
        end
    end

    // Full 64-bit product; sign extension to 64 bits makes the low 64 product bits exact.
    always_comb begin
        mul_signed_s = (sel_s.op == OP_MULT);
        a_ext_s      = {{32{mul_signed_s & sel_s.a[31]}}, sel_s.a};
        b_ext_s      = {{32{mul_signed_s & sel_s.b[31]}}, sel_s.b};
        product_s    = a_ext_s * b_ext_s;
    end

    // Next-state, latency counter and result-register sequencing.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        prod_d      = prod_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        div_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_s.valid) begin
                    if (is_div_op(sel_s.op)) begin
                        state_d     = ST_DIV;
                        counter_d   = CNT_DIV;
                        div_start_s = 1'b1;
                    end else if (MUL_LAT == 32'sd1) begin
                        state_d   = ST_DONE;
                        counter_d = CNT_ZERO;
                        prod_d    = product_s;
                        hi_d      = product_s[63:32];
                        lo_d      = product_s[31:0];
                    end else begin
                        state_d   = ST_MUL;
                        counter_d = CNT_MUL;
                        prod_d    = product_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d   = ST_IDLE;
                    counter_d = CNT_ZERO;
                end else if (counter_q == CNT_ONE) begin
                    state_d   = ST_DONE;
                    counter_d = CNT_ZERO;
                    hi_d      = prod_q[63:32];
                    lo_d      = prod_q[31:0];
                end else begin
                    counter_d = counter_q - CNT_ONE;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d   = ST_IDLE;
                    counter_d = CNT_ZERO;
                end else if (counter_q == CNT_ONE) begin
                    state_d   = ST_SIGN;
                    counter_d = CNT_ZERO;
                end else begin
                    counter_d = counter_q - CNT_ONE;
                end
            end
            ST_SIGN: begin
                if (flush) begin
                    state_d   = ST_IDLE;
                    counter_d = CNT_ZERO;
                end else if (div_ready_s) begin
                    state_d = ST_DONE;
                    hi_d    = div_rem_s;
                    lo_d    = div_quo_s;
                end else begin
                    state_d = ST_SIGN;
                end
            end
            // A result in DONE is already committed, so flush does not suppress it.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = CNT_ZERO;
            end
        endcase
    end

    // Scheduler state and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= CNT_ZERO;
            prod_q    <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            prod_q    <= prod_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    muldiv_sched_div_radix2 u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_s),
        .flush     (flush),
        .is_signed (sel_s.op == OP_DIV),
        .a         (sel_s.a),
        .b         (sel_s.b),
        .ready     (div_ready_s),
        .quo       (div_quo_s),
        .rem       (div_rem_s)
    );

    assign grant = grant_s;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign stall = busy | (req[1] & req[0]) | ((|req) & ~(|grant_s));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: stimulus pushes expected HI/LO and the
// expected done cycle; a monitor pops on every done pulse and compares.
module tb_muldiv_sched;
    import muldiv_sched_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [1:0][1:0]  op = '0;
    logic [1:0][31:0] src_a = '0;
    logic [1:0][31:0] src_b = '0;
    logic             flush = 1'b0;
    logic [1:0]       grant;
    logic             busy, stall, done;
    logic [31:0]      hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    muldiv_sched #(.MUL_LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .grant (grant),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hi", 64'(hi), 64'(mon_e.hi));
                check("lo", 64'(lo), 64'(mon_e.lo));
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic push_exp(input logic [31:0] ehi, input logic [31:0] elo, input int at);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // Present a request on one lane, wait for its grant, record the expectation.
    task automatic issue(input int lane, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] ehi,
                         input logic [31:0] elo, input int lat, output int t);
        req[lane]   = 1'b1;
        op[lane]    = o;
        src_a[lane] = a;
        src_b[lane] = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (grant != 2'b00) break;
        end
        check("grant", 64'(grant), (lane == 1) ? 64'd2 : 64'd1);
        t = cyc;
        if (push) push_exp(ehi, elo, t + lat);
        @(posedge clk);
        #1;
        req = 2'b00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // MULTU with busy window T+1..T+3
        issue(1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'hFFFF_FFFE, 3, t);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mul_busy", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("mul_busy_end", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Both lanes request; lane 1 first, lane 0 held and granted at T+4
        req = 2'b11;
        op[1] = OP_MULT; src_a[1] = 32'd3; src_b[1] = 32'd4;
        op[0] = OP_MULT; src_a[0] = 32'd5; src_b[0] = 32'd6;
        @(negedge clk);
        check("dual_grant1", 64'(grant), 64'd2);
        check("dual_stall", 64'(stall), 64'd1);
        t = cyc;
        push_exp(32'd0, 32'd12, t + 3);
        @(posedge clk);
        #1;
        req = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("held_stall", 64'(stall), 64'd1);
        end
        @(negedge clk);
        check("dual_grant0", 64'(grant), 64'd1);
        check("dual_grant0_cyc", 64'(cyc), 64'(t + 4));
        push_exp(32'd0, 32'd30, cyc + 3);
        @(posedge clk);
        #1;
        req = 2'b00;
        wait_idle();

        // Signed multiply and divides
        issue(0, OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 3, t);
        wait_idle();
        issue(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, t);
        wait_idle();
        issue(1, OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 34, t);
        wait_idle();
        issue(0, OP_DIVU, 32'h0000_1234, 32'd0, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 34, t);
        wait_idle();
        issue(0, OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 34, t);
        wait_idle();
        issue(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 34, t);
        wait_idle();
        issue(0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 34, t);
        wait_idle();
        issue(0, OP_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b1, 32'd5, 32'h1999_9999, 34, t);
        wait_idle();

        // Flush in IDLE blocks the grant but keeps stall up
        flush = 1'b1;
        req[0] = 1'b1; op[0] = OP_MULT; src_a[0] = 32'd2; src_b[0] = 32'd3;
        @(negedge clk);
        check("flush_idle_grant", 64'(grant), 64'd0);
        check("flush_idle_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        issue(0, OP_MULT, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 3, t);
        wait_idle();

        // Flush at T+10 of a divide: no done, result held, new request granted at T+11
        issue(0, OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 34, t);
        while (cyc < t + 10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req[1] = 1'b1; op[1] = OP_MULTU; src_a[1] = 32'd6; src_b[1] = 32'd7;
        @(negedge clk);
        check("flush_cycle", 64'(cyc), 64'(t + 11));
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi_hold", 64'(hi), 64'd0);
        check("flush_lo_hold", 64'(lo), 64'd6);
        check("post_flush_grant", 64'(grant), 64'd2);
        push_exp(32'd0, 32'd42, cyc + 3);
        @(posedge clk);
        #1;
        req = 2'b00;
        wait_idle();

        // Asynchronous reset between edges in the middle of a divide
        issue(1, OP_DIV, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 34, t);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (45) @(negedge clk);
        check("arst_quiet", 64'(busy), 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
